// File: rtl/cmp_sweep_if.sv
// Bundle between the comparator sweep tester and the comparator/board side.
// Master = tester (drives operands and status); slave = comparator/board.
// No storage; pure wiring.
interface cmp_sweep_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       err_cnt;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic [2:0]       fail_y;

    modport master (
        input  start, Y,
        output A, B, busy, done, pass, err_cnt, fail_a, fail_b, fail_y
    );

    modport slave (
        output start, Y,
        input  A, B, busy, done, pass, err_cnt, fail_a, fail_b, fail_y
    );
endinterface

// File: rtl/cmp_sweep_tester.sv
// Sweeps every (A,B) pair onto an external comparator and checks Y against a reference.
// Latency: each vector takes SETTLE+1 cycles; a full sweep ends 2^(2*WIDTH)*(SETTLE+1) edges after start.
// No backpressure: start is only honoured in IDLE/DONE and ignored while busy.
module cmp_sweep_tester #(
    parameter int WIDTH       = 4,
    parameter int SETTLE      = 2,
    parameter int STOP_ON_ERR = 0
) (
    input  logic          clk,
    input  logic          rst,
    cmp_sweep_if.master   bus
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic [2:0]       fail_y_q, fail_y_d;

    logic [2:0] ref_y;
    logic       mismatch;
    logic       last_vec;
    logic [7:0] err_nxt;

    // Reference result and error bookkeeping for the vector currently on A/B.
    // Any deviation, including non-one-hot Y, counts as a mismatch.
    assign ref_y    = {a_q > b_q, a_q == b_q, a_q < b_q};
    assign mismatch = (bus.Y != ref_y);
    assign last_vec = (a_q == {WIDTH{1'b1}}) && (b_q == {WIDTH{1'b1}});
    assign err_nxt  = (mismatch && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

    // State register and all output/datapath flops; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            fail_y_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            fail_a_q  <= fail_a_d;
            fail_b_q  <= fail_b_d;
            fail_y_q  <= fail_y_d;
        end
    end

    // Next-state logic: SETTLE holds for exactly SETTLE cycles, CHECK for one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (last_vec || ((STOP_ON_ERR != 0) && mismatch)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: launch on start, score and step the vector in CHECK, hold in DONE.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        fail_a_d  = fail_a_q;
        fail_b_d  = fail_b_q;
        fail_y_d  = fail_y_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d       = '0;
                    b_d       = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                    fail_a_d  = '0;
                    fail_b_d  = '0;
                    fail_y_d  = '0;
                end
            end
            S_CHECK: begin
                err_cnt_d = err_nxt;
                if (mismatch && (err_cnt_q == 8'd0)) begin
                    fail_a_d = a_q;
                    fail_b_d = b_q;
                    fail_y_d = bus.Y;
                end
                if (state_d == S_DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_nxt == 8'd0);
                end else if (b_q == {WIDTH{1'b1}}) begin
                    b_d = '0;
                    a_d = a_q + 1'b1;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.fail_a  = fail_a_q;
    assign bus.fail_b  = fail_b_q;
    assign bus.fail_y  = fail_y_q;

endmodule

// File: tb/tb_cmp_sweep_tester.sv
// Directed bench for cmp_sweep_tester with a behavioural comparator that can be made faulty.
// Two instances: full-sweep (STOP_ON_ERR=0) and stop-on-error (STOP_ON_ERR=1).
module tb_cmp_sweep_tester;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   ecnt  = 0;
    int   mode0 = 0;
    int   mode1 = 0;

    always #5 clk = ~clk;

    cmp_sweep_if #(.WIDTH(4)) if0 ();
    cmp_sweep_if #(.WIDTH(4)) if1 ();

    cmp_sweep_tester #(.WIDTH(4), .SETTLE(2), .STOP_ON_ERR(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    cmp_sweep_tester #(.WIDTH(4), .SETTLE(2), .STOP_ON_ERR(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    // Comparator model: 0 ideal, 1 A==B reported as A>B, 2 stuck 000, 3 wrong only at (5,7).
    function automatic logic [2:0] cmp_model(input int m, input logic [3:0] a, input logic [3:0] b);
        logic [2:0] y;
        y = {a > b, a == b, a < b};
        case (m)
            1: if (a == b) y = 3'b100;
            2: y = 3'b000;
            3: if (a == 4'd5 && b == 4'd7) y = 3'b100;
            default: ;
        endcase
        return y;
    endfunction

    always_comb if0.Y = cmp_model(mode0, if0.A, if0.B);
    always_comb if1.Y = cmp_model(mode1, if1.A, if1.B);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic pulse(input int which);
        if (which == 0) if0.start = 1'b1; else if1.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        ecnt = 0;
    endtask

    task automatic wait_done(input int which, input string tag);
        logic d;
        d = (which == 0) ? if0.done : if1.done;
        while (!d && ecnt < 3000) begin
            tick();
            d = (which == 0) ? if0.done : if1.done;
        end
        chk(tag, {31'd0, d}, 32'd1);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_A"},    {28'd0, if0.A},      32'd0);
        chk({tag, "_B"},    {28'd0, if0.B},      32'd0);
        chk({tag, "_busy"}, {31'd0, if0.busy},   32'd0);
        chk({tag, "_done"}, {31'd0, if0.done},   32'd0);
        chk({tag, "_pass"}, {31'd0, if0.pass},   32'd0);
        chk({tag, "_err"},  {24'd0, if0.err_cnt}, 32'd0);
        chk({tag, "_fa"},   {28'd0, if0.fail_a}, 32'd0);
        chk({tag, "_fb"},   {28'd0, if0.fail_b}, 32'd0);
        chk({tag, "_fy"},   {29'd0, if0.fail_y}, 32'd0);
    endtask

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero0("rst0");
        chk("rst1_busy", {31'd0, if1.busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, if0.busy}, 32'd0);

        // 1: ideal comparator, full sweep
        mode0 = 0;
        pulse(0);
        chk("t1_busy", {31'd0, if0.busy}, 32'd1);
        chk("t1_A0", {28'd0, if0.A}, 32'd0);
        chk("t1_B0", {28'd0, if0.B}, 32'd0);
        repeat (3) tick();
        chk("t1_B1", {28'd0, if0.B}, 32'd1);
        wait_done(0, "t1_done");
        chk("t1_edges", ecnt, 32'd768);
        chk("t1_pass", {31'd0, if0.pass}, 32'd1);
        chk("t1_busy_end", {31'd0, if0.busy}, 32'd0);
        chk("t1_err", {24'd0, if0.err_cnt}, 32'd0);
        chk("t1_fa", {28'd0, if0.fail_a}, 32'd0);
        chk("t1_fb", {28'd0, if0.fail_b}, 32'd0);
        chk("t1_fy", {29'd0, if0.fail_y}, 32'd0);
        chk("t1_Ahold", {28'd0, if0.A}, 32'd15);
        chk("t1_Bhold", {28'd0, if0.B}, 32'd15);

        // 6a: start re-pulsed at vector 10 is ignored
        pulse(0);
        repeat (30) tick();
        chk("t6_A10", {28'd0, if0.A}, 32'd0);
        chk("t6_B10", {28'd0, if0.B}, 32'd10);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("t6_busy", {31'd0, if0.busy}, 32'd1);
        chk("t6_B10b", {28'd0, if0.B}, 32'd10);
        wait_done(0, "t6_done");
        chk("t6_edges", ecnt, 32'd768);
        chk("t6_pass", {31'd0, if0.pass}, 32'd1);

        // 2: A==B reported as A>B
        mode0 = 1;
        pulse(0);
        wait_done(0, "t2_done");
        chk("t2_edges", ecnt, 32'd768);
        chk("t2_pass", {31'd0, if0.pass}, 32'd0);
        chk("t2_err", {24'd0, if0.err_cnt}, 32'd16);
        chk("t2_fa", {28'd0, if0.fail_a}, 32'd0);
        chk("t2_fb", {28'd0, if0.fail_b}, 32'd0);
        chk("t2_fy", {29'd0, if0.fail_y}, 32'd4);

        // 3: Y stuck at 000, counter saturates
        mode0 = 2;
        pulse(0);
        wait_done(0, "t3_done");
        chk("t3_pass", {31'd0, if0.pass}, 32'd0);
        chk("t3_err", {24'd0, if0.err_cnt}, 32'd255);
        chk("t3_fa", {28'd0, if0.fail_a}, 32'd0);
        chk("t3_fb", {28'd0, if0.fail_b}, 32'd0);
        chk("t3_fy", {29'd0, if0.fail_y}, 32'd0);

        // 6b: start from DONE clears counters and reruns
        mode0 = 0;
        pulse(0);
        chk("t6b_err", {24'd0, if0.err_cnt}, 32'd0);
        chk("t6b_done", {31'd0, if0.done}, 32'd0);
        chk("t6b_pass", {31'd0, if0.pass}, 32'd0);
        chk("t6b_busy", {31'd0, if0.busy}, 32'd1);
        wait_done(0, "t6b_fin");
        chk("t6b_edges", ecnt, 32'd768);
        chk("t6b_pass2", {31'd0, if0.pass}, 32'd1);

        // 5: asynchronous reset mid-sweep at vector 40
        pulse(0);
        repeat (120) tick();
        chk("t5_A", {28'd0, if0.A}, 32'd2);
        chk("t5_B", {28'd0, if0.B}, 32'd8);
        rst = 1'b1;
        #1;
        chk_zero0("t5_rst");
        tick();
        rst = 1'b0;
        tick();
        pulse(0);
        wait_done(0, "t5_done");
        chk("t5_edges", ecnt, 32'd768);
        chk("t5_pass", {31'd0, if0.pass}, 32'd1);
        chk("t5_err", {24'd0, if0.err_cnt}, 32'd0);

        // 4: stop-on-error instance, fault only at A=5,B=7
        mode1 = 3;
        pulse(1);
        wait_done(1, "t4_done");
        chk("t4_edges", ecnt, 32'd264);
        chk("t4_err", {24'd0, if1.err_cnt}, 32'd1);
        chk("t4_fa", {28'd0, if1.fail_a}, 32'd5);
        chk("t4_fb", {28'd0, if1.fail_b}, 32'd7);
        chk("t4_fy", {29'd0, if1.fail_y}, 32'd4);
        chk("t4_pass", {31'd0, if1.pass}, 32'd0);
        chk("t4_Ahold", {28'd0, if1.A}, 32'd5);
        chk("t4_Bhold", {28'd0, if1.B}, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
